// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared defaults and width helpers for the synchronous FIFO
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

    localparam int unsigned c_DEFAULT_WIDTH = 16;
    localparam int unsigned c_DEFAULT_DEPTH = 8;

    // Occupancy must represent 0..depth inclusive, hence depth+1 codes.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Address width for a depth-entry array; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : WIDTH x DEPTH storage, one write port, one registered read
//                port whose output holds when no read is requested
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int AW    = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port; the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; a same-address write in the same cycle returns old data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule : fifo_mem
`default_nettype wire

// File: rtl/sync_fifo_gen2.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_gen2
//  Description : Single-clock FIFO with arbitrary depth, level flags, flush
//                and registered accept/reject status pulses
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_gen2
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = c_DEFAULT_WIDTH,
    parameter int FIFO_DEPTH = c_DEFAULT_DEPTH,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               wr_en,
    input  logic [FIFO_WIDTH-1:0]              data_in,
    input  logic                               rd_en,
    output logic [FIFO_WIDTH-1:0]              data_out,
    output logic                               rd_valid,
    output logic                               wr_ack,
    output logic                               overflow,
    output logic                               underflow,
    output logic                               full,
    output logic                               empty,
    output logic                               almostfull,
    output logic                               almostempty,
    output logic [cnt_width(FIFO_DEPTH)-1:0]   count
);

    localparam int c_CW = cnt_width(FIFO_DEPTH);
    localparam int c_PW = ptr_width(FIFO_DEPTH);

    // Reject illegal configurations at elaboration.
    if (FIFO_WIDTH < 1) begin : g_bad_width
        $fatal(1, "sync_fifo_gen2: FIFO_WIDTH must be >= 1");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $fatal(1, "sync_fifo_gen2: FIFO_DEPTH must be >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH - 1) begin : g_bad_af
        $fatal(1, "sync_fifo_gen2: AF_LEVEL must be in 1..FIFO_DEPTH-1");
    end
    if (AE_LEVEL < 1 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
        $fatal(1, "sync_fifo_gen2: AE_LEVEL must be in 1..FIFO_DEPTH-1");
    end

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            w_rd_acc;
    logic            w_wr_acc;

    // A read needs stored data; a write into a full FIFO is allowed only when
    // a read frees a slot at the same edge. A write never satisfies an empty read.
    always_comb begin
        w_rd_acc = rd_en && !flush && (r_count != '0);
        w_wr_acc = wr_en && !flush && ((r_count < c_CW'(FIFO_DEPTH)) || w_rd_acc);
    end

    // Pointers, occupancy and status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == c_PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + c_PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == c_PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + c_PW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
            wr_ack    <= w_wr_acc;
            overflow  <= wr_en && !w_wr_acc;
            underflow <= rd_en && (r_count == '0);
            rd_valid  <= w_rd_acc;
        end
    end

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (c_PW)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (data_out)
    );

    // Level flags decoded directly from occupancy.
    always_comb begin
        count       = r_count;
        full        = (r_count == c_CW'(FIFO_DEPTH));
        empty       = (r_count == '0);
        almostfull  = (r_count >= c_CW'(AF_LEVEL)) && !full;
        almostempty = (r_count <= c_CW'(AE_LEVEL)) && !empty;
    end

endmodule : sync_fifo_gen2
`default_nettype wire

// File: tb/tb_sync_fifo_gen2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_gen2
//  Description : Self-checking bench: directed vector table on an 8-deep FIFO
//                plus queue-model comparison of an 8-deep and a 5-deep FIFO
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sync_fifo_gen2;

    localparam int D0 = 8, AF0 = 6, AE0 = 2;
    localparam int D1 = 5, AF1 = 3, AE1 = 1;

    logic        clk = 1'b0;
    logic        rst_n, flush, wr_en, rd_en;
    logic [15:0] data_in;

    logic [15:0] d0_dout, d1_dout;
    logic        d0_rv, d0_ack, d0_ovf, d0_unf, d0_full, d0_empty, d0_af, d0_ae;
    logic        d1_rv, d1_ack, d1_ovf, d1_unf, d1_full, d1_empty, d1_af, d1_ae;
    logic [3:0]  d0_cnt;
    logic [2:0]  d1_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_gen2 #(.FIFO_WIDTH(16), .FIFO_DEPTH(D0), .AF_LEVEL(AF0), .AE_LEVEL(AE0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(d0_dout), .rd_valid(d0_rv), .wr_ack(d0_ack),
        .overflow(d0_ovf), .underflow(d0_unf), .full(d0_full), .empty(d0_empty),
        .almostfull(d0_af), .almostempty(d0_ae), .count(d0_cnt)
    );

    sync_fifo_gen2 #(.FIFO_WIDTH(16), .FIFO_DEPTH(D1), .AF_LEVEL(AF1), .AE_LEVEL(AE1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(d1_dout), .rd_valid(d1_rv), .wr_ack(d1_ack),
        .overflow(d1_ovf), .underflow(d1_unf), .full(d1_full), .empty(d1_empty),
        .almostfull(d1_af), .almostempty(d1_ae), .count(d1_cnt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference: a queue per instance -------------
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int mdout[2], mrv[2], mack[2], movf[2], munf[2];

    // Advance both models by one clock using the inputs present before the edge.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int n, dep;
            bit racc, wacc;
            dep = (k == 0) ? D0 : D1;
            n   = (k == 0) ? q0.size() : q1.size();
            if (!rst_n || flush) begin
                if (k == 0) q0.delete(); else q1.delete();
                if (!rst_n) mdout[k] = 0;
                mrv[k] = 0; mack[k] = 0; movf[k] = 0; munf[k] = 0;
            end else begin
                racc = rd_en && (n > 0);
                wacc = wr_en && ((n < dep) || racc);
                if (racc) mdout[k] = (k == 0) ? int'(q0.pop_front()) : int'(q1.pop_front());
                if (wacc) begin
                    if (k == 0) q0.push_back(data_in); else q1.push_back(data_in);
                end
                mack[k] = int'(wacc);
                movf[k] = int'(wr_en && !wacc);
                munf[k] = int'(rd_en && (n == 0));
                mrv[k]  = int'(racc);
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            int n, dep, af, ae;
            string p;
            p   = (k == 0) ? "d8" : "d5";
            dep = (k == 0) ? D0 : D1;
            af  = (k == 0) ? AF0 : AF1;
            ae  = (k == 0) ? AE0 : AE1;
            n   = (k == 0) ? q0.size() : q1.size();
            chk({p, ".count"}, (k == 0) ? int'(d0_cnt) : int'(d1_cnt), n);
            chk({p, ".data_out"}, (k == 0) ? int'(d0_dout) : int'(d1_dout), mdout[k]);
            chk({p, ".rd_valid"}, (k == 0) ? int'(d0_rv) : int'(d1_rv), mrv[k]);
            chk({p, ".wr_ack"}, (k == 0) ? int'(d0_ack) : int'(d1_ack), mack[k]);
            chk({p, ".overflow"}, (k == 0) ? int'(d0_ovf) : int'(d1_ovf), movf[k]);
            chk({p, ".underflow"}, (k == 0) ? int'(d0_unf) : int'(d1_unf), munf[k]);
            chk({p, ".full"}, (k == 0) ? int'(d0_full) : int'(d1_full), int'(n == dep));
            chk({p, ".empty"}, (k == 0) ? int'(d0_empty) : int'(d1_empty), int'(n == 0));
            chk({p, ".almostfull"}, (k == 0) ? int'(d0_af) : int'(d1_af), int'(n >= af && n != dep));
            chk({p, ".almostempty"}, (k == 0) ? int'(d0_ae) : int'(d1_ae), int'(n <= ae && n != 0));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table for the 8-deep instance -----------
    typedef struct {
        bit          rst_n, flush, wr, rd;
        logic [15:0] din;
        int          cnt;
        int          dout;
        bit          rv, ack, ovf, unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit r, input bit f, input bit w, input bit rd,
                                input int din, input int cnt, input int dout,
                                input bit rv, input bit ack, input bit ovf, input bit unf);
        vec_t v;
        v.rst_n = r; v.flush = f; v.wr = w; v.rd = rd; v.din = 16'(din);
        v.cnt = cnt; v.dout = dout; v.rv = rv; v.ack = ack; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        for (int k = 0; k < 2; k++) begin
            mdout[k] = 0; mrv[k] = 0; mack[k] = 0; movf[k] = 0; munf[k] = 0;
        end

        // reset
        tbl.push_back(mk(0,0,0,0,0,       0, 0,      0,0,0,0));
        // fill 0x0001..0x0008
        for (int i = 1; i <= 8; i++) tbl.push_back(mk(1,0,1,0,i, i, 0, 0,1,0,0));
        // ninth write rejected
        tbl.push_back(mk(1,0,1,0,9,       8, 0,      0,0,1,0));
        // full with simultaneous read and write
        tbl.push_back(mk(1,0,1,1,'hBEEF,  8, 'h0001, 1,1,0,0));
        // drain in order, 0xBEEF last
        for (int i = 2; i <= 8; i++) tbl.push_back(mk(1,0,0,1,0, 9 - i, i, 1,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,       0, 'hBEEF, 1,0,0,0));
        // read on empty
        tbl.push_back(mk(1,0,0,1,0,       0, 'hBEEF, 0,0,0,1));
        // read+write on empty: write only
        tbl.push_back(mk(1,0,1,1,'h00AA,  1, 'hBEEF, 0,1,0,1));
        tbl.push_back(mk(1,0,0,1,0,       0, 'h00AA, 1,0,0,0));
        // count to 5 then flush with wr_en
        for (int i = 1; i <= 5; i++) tbl.push_back(mk(1,0,1,0,'h10 + i, i, 'h00AA, 0,1,0,0));
        tbl.push_back(mk(1,1,1,0,'h77,    0, 'h00AA, 0,0,0,0));
        // count to 3 then reset mid-operation
        for (int i = 1; i <= 3; i++) tbl.push_back(mk(1,0,1,0,'h20 + i, i, 'h00AA, 0,1,0,0));
        tbl.push_back(mk(0,0,1,0,'h55,    0, 0,      0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,       0, 0,      0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst_n; flush = tbl[i].flush;
            wr_en = tbl[i].wr; rd_en = tbl[i].rd; data_in = tbl[i].din;
            cycle();
            chk($sformatf("vec%0d.count", i), int'(d0_cnt), tbl[i].cnt);
            chk($sformatf("vec%0d.data_out", i), int'(d0_dout), tbl[i].dout);
            chk($sformatf("vec%0d.rd_valid", i), int'(d0_rv), int'(tbl[i].rv));
            chk($sformatf("vec%0d.wr_ack", i), int'(d0_ack), int'(tbl[i].ack));
            chk($sformatf("vec%0d.overflow", i), int'(d0_ovf), int'(tbl[i].ovf));
            chk($sformatf("vec%0d.underflow", i), int'(d0_unf), int'(tbl[i].unf));
            chk($sformatf("vec%0d.full", i), int'(d0_full), int'(tbl[i].cnt == 8));
            chk($sformatf("vec%0d.empty", i), int'(d0_empty), int'(tbl[i].cnt == 0));
            chk($sformatf("vec%0d.almostfull", i), int'(d0_af), int'(tbl[i].cnt >= 6 && tbl[i].cnt < 8));
            chk($sformatf("vec%0d.almostempty", i), int'(d0_ae), int'(tbl[i].cnt >= 1 && tbl[i].cnt <= 2));
            check_model();
        end

        // 12 writes interleaved with reads: the 5-deep pointers wrap repeatedly
        rst_n = 1'b1; flush = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wr_en = 1'b1; rd_en = (i % 3 != 0); data_in = 16'h0100 + 16'(i);
            cycle();
            check_model();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd_en = 1'b1;
            cycle();
            check_model();
        end

        // randomized traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            flush   = ($urandom_range(0, 39) == 0);
            wr_en   = ($urandom_range(0, 99) < 55);
            rd_en   = ($urandom_range(0, 99) < 45);
            data_in = 16'($urandom);
            cycle();
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sync_fifo_gen2
`default_nettype wire

// File: doc/sync_fifo_gen2.md
SYNC_FIFO_GEN2 -- requirements
Module: sync_fifo_gen2

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, data word width (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entry count (>=2, need not be a power of two).
REQ-003 SHALL have parameter AF_LEVEL, default FIFO_DEPTH-2, almost-full threshold (1..FIFO_DEPTH-1).
REQ-004 SHALL have parameter AE_LEVEL, default 1, almost-empty threshold (1..FIFO_DEPTH-1).
REQ-005 SHALL have port clk, in, 1, sole clock, all logic on rising edge.
REQ-006 SHALL have port rst_n, in, 1, reset, synchronous and active-low.
REQ-007 SHALL have port flush, in, 1, synchronous clear of contents.
REQ-008 SHALL have port wr_en, in, 1, write request.
REQ-009 SHALL have port data_in, in, FIFO_WIDTH, write data.
REQ-010 SHALL have port rd_en, in, 1, read request.
REQ-011 SHALL have port data_out, out, FIFO_WIDTH, registered read data.
REQ-012 SHALL have port rd_valid, out, 1, data_out updated this cycle.
REQ-013 SHALL have port wr_ack, out, 1, previous-cycle write accepted.
REQ-014 SHALL have ports overflow and underflow, out, 1 each, previous-cycle rejected write/read.
REQ-015 SHALL have ports full, empty, almostfull, almostempty, out, 1 each, level flags.
REQ-016 SHALL have port count, out, $clog2(FIFO_DEPTH+1), current occupancy.

Function
REQ-017 Write accepted iff wr_en && !flush && (count<FIFO_DEPTH || read accepted same cycle).
REQ-018 Read accepted iff rd_en && !flush && count!=0; read on empty is never satisfied by a same-cycle write.
REQ-019 Accepted write stores data_in at wr_ptr; accepted read loads data_out from rd_ptr at the same edge (latency 1, rd_valid=1 next cycle).
REQ-020 Pointers SHALL advance by 1 and wrap from FIFO_DEPTH-1 to 0.
REQ-021 count: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds FIFO_DEPTH or drops below 0.
REQ-022 wr_ack, overflow, underflow, rd_valid SHALL be registered single-cycle pulses reflecting the previous cycle's request.
REQ-023 overflow=1 iff previous cycle wr_en && write rejected && !flush; underflow=1 iff previous cycle rd_en && count==0 && !flush.
REQ-024 Full and simultaneous wr_en+rd_en: both accepted, count stays FIFO_DEPTH, no overflow.
REQ-025 Empty and simultaneous wr_en+rd_en: write accepted, read rejected, underflow=1, count becomes 1.
REQ-026 full=(count==FIFO_DEPTH); empty=(count==0); combinational from count.
REQ-027 almostfull=(count>=AF_LEVEL && !full); almostempty=(count<=AE_LEVEL && !empty).
REQ-028 data_out SHALL hold its value when no read is accepted.
REQ-029 flush=1: next edge pointers and count to 0, pulses to 0, data_out held, wr_en/rd_en ignored that cycle.

Reset
REQ-030 rst_n=0 at a rising edge SHALL set pointers, count, data_out, wr_ack, overflow, underflow, rd_valid to 0; rst_n has priority over flush, wr_en and rd_en.
REQ-031 After reset: empty=1, full=0, almostfull=0, almostempty=0; reset mid-operation discards all contents.
REQ-032 Storage array SHALL NOT be reset.

Structure
REQ-033 Package fifo_pkg SHALL hold default width/depth constants and a function computing count width.
REQ-034 Storage SHALL be sub-module fifo_mem (1 write port, 1 registered read port, FIFO_WIDTH x FIFO_DEPTH).
REQ-035 Parameter legality (depth, thresholds) SHALL be checked at elaboration with a fatal error.

Verification
REQ-036 DEPTH=8: reset, write 0x0001..0x0008 -> full=1 after 8th edge, wr_ack each cycle, 9th write -> overflow=1, count=8.
REQ-037 DEPTH=8 full: wr_en+rd_en with 0xBEEF -> data_out=0x0001, rd_valid=1, count=8, no overflow; 0xBEEF read out 8th.
REQ-038 Empty: rd_en -> underflow=1, rd_valid=0; rd_en+wr_en 0x00AA -> underflow=1, count=1, next read returns 0x00AA.
REQ-039 DEPTH=5: 12 writes interleaved with reads -> pointers wrap 4->0, data order preserved, count never >5.
REQ-040 DEPTH=8, AF_LEVEL=6, AE_LEVEL=2: fill 0..8 -> almostempty at 1..2, almostfull at 6..7, both 0 at 0 and 8.
REQ-041 Count=5: flush with wr_en=1 -> count=0, empty=1, wr_ack=0; rst_n=0 at count=3 -> all outputs reset values next edge.
